// File: rtl/mux_pipe_reg.sv
// mux_pipe_reg: N-channel select-and-register pipeline stage.
// A binary sel picks one of N channels, and the chosen channel is captured in
// a register. The register supports stall, bubble, valid/source tracking, a
// sticky out-of-range select flag and a saturating stall-length counter.
module mux_pipe_reg #(
  parameter int               WIDTH      = 64,
  parameter int               N          = 4,
  parameter int               SELW       = 2,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int               CNTW       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]      sel,
  input  logic                 stall,
  input  logic                 bubble,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SELW-1:0]      out_src,
  output logic                 sel_err,
  output logic [CNTW-1:0]      stall_cnt
);

  // The register is either empty (holding BUBBLE_VAL) or full (holding a
  // real selected channel).
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  // Reject channel counts outside 2..16 and selects too narrow to address
  // every channel.
  if (N < 2 || N > 16) begin : g_bad_n
    $error("mux_pipe_reg: N must be in the range 2..16");
  end
  if (N > (1 << SELW)) begin : g_bad_selw
    $error("mux_pipe_reg: SELW too narrow for N channels");
  end

  logic [0:0]       state_q,    state_d;
  logic [WIDTH-1:0] data_q,     data_d;
  logic [SELW-1:0]  src_q,      src_d;
  logic             selErr_q,   selErr_d;
  logic [CNTW-1:0]  stallCnt_q, stallCnt_d;

  logic [WIDTH-1:0] chanData;
  logic             chanHit;

  // Plain binary channel decode. chanHit is low when sel does not name an
  // existing channel.
  always_comb begin
    chanData = BUBBLE_VAL;
    chanHit  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        chanData = in_data[k*WIDTH +: WIDTH];
        chanHit  = 1'b1;
      end
    end
  end

  // Next-state selection. Exactly one action applies per edge, in the order
  // bubble, then stall, then load.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    src_d      = src_q;
    selErr_d   = selErr_q;
    stallCnt_d = stallCnt_q;
    if (bubble) begin
      state_d    = ST_EMPTY;
      data_d     = BUBBLE_VAL;
      src_d      = '0;
      stallCnt_d = '0;
    end else if (stall) begin
      if (stallCnt_q != CNT_MAX) begin
        stallCnt_d = stallCnt_q + CNTW'(1);
      end
    end else begin
      stallCnt_d = '0;
      if (chanHit) begin
        state_d = ST_FULL;
        data_d  = chanData;
        src_d   = sel;
      end else begin
        state_d  = ST_EMPTY;
        data_d   = BUBBLE_VAL;
        src_d    = '0;
        selErr_d = 1'b1;
      end
    end
  end

  // State register. Reset clears it immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      data_q     <= BUBBLE_VAL;
      src_q      <= '0;
      selErr_q   <= 1'b0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      src_q      <= src_d;
      selErr_q   <= selErr_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state_q == ST_FULL);
  assign out_src   = src_q;
  assign sel_err   = selErr_q;
  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_mux_pipe_reg.sv
// tb_mux_pipe_reg: checks two configurations of mux_pipe_reg against an
// expected-value model. The first is the default 4x64 configuration. The
// second is 3 channels of 16 bits, CNTW=3 and a nonzero BUBBLE_VAL.
module tb_mux_pipe_reg;

  localparam int          W3  = 16;
  localparam int          N3  = 3;
  localparam int          CW3 = 3;
  localparam logic [15:0] BV3 = 16'hDEAD;

  logic clk;
  logic rst;

  logic [255:0] in_main;
  logic [1:0]   sel_m;
  logic         stall_m, bub_m;
  logic [63:0]  o_data_m;
  logic         o_valid_m, o_err_m;
  logic [1:0]   o_src_m;
  logic [7:0]   o_cnt_m;

  logic [47:0]  in3;
  logic [1:0]   sel3;
  logic         stall3, bub3;
  logic [15:0]  o_data3;
  logic         o_valid3, o_err3;
  logic [1:0]   o_src3;
  logic [2:0]   o_cnt3;

  logic [63:0] m_data;
  logic        m_valid, m_err;
  int          m_src, m_cnt;
  logic [15:0] m3_data;
  logic        m3_valid, m3_err;
  int          m3_src, m3_cnt;

  int checks = 0;
  int errors = 0;

  mux_pipe_reg dut (
    .clk(clk), .rst(rst), .in_data(in_main), .sel(sel_m), .stall(stall_m),
    .bubble(bub_m), .out_data(o_data_m), .out_valid(o_valid_m),
    .out_src(o_src_m), .sel_err(o_err_m), .stall_cnt(o_cnt_m)
  );

  mux_pipe_reg #(.WIDTH(W3), .N(N3), .SELW(2), .BUBBLE_VAL(BV3), .CNTW(CW3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in3), .sel(sel3), .stall(stall3),
    .bubble(bub3), .out_data(o_data3), .out_valid(o_valid3),
    .out_src(o_src3), .sel_err(o_err3), .stall_cnt(o_cnt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic reset_models();
    m_data  = '0;  m_valid  = 1'b0; m_src  = 0; m_err  = 1'b0; m_cnt  = 0;
    m3_data = BV3; m3_valid = 1'b0; m3_src = 0; m3_err = 1'b0; m3_cnt = 0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 8; i++) in_main[i*32 +: 32] = $urandom;
    in3   = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
    sel_m = 2'($urandom_range(0, 3));
    sel3  = 2'($urandom_range(0, 3));
  endtask

  // One rising edge. The model updates from the inputs that were present at
  // the edge. Outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      reset_models();
    end else begin
      if (bub_m) begin
        m_data = '0; m_valid = 1'b0; m_src = 0; m_cnt = 0;
      end else if (stall_m) begin
        m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
      end else begin
        m_cnt = 0;
        m_data = in_main[int'(sel_m)*64 +: 64]; m_valid = 1'b1; m_src = int'(sel_m);
      end
      if (bub3) begin
        m3_data = BV3; m3_valid = 1'b0; m3_src = 0; m3_cnt = 0;
      end else if (stall3) begin
        m3_cnt = (m3_cnt + 1 > (1 << CW3) - 1) ? (1 << CW3) - 1 : m3_cnt + 1;
      end else begin
        m3_cnt = 0;
        if (int'(sel3) < N3) begin
          m3_data = in3[int'(sel3)*W3 +: W3]; m3_valid = 1'b1; m3_src = int'(sel3);
        end else begin
          m3_data = BV3; m3_valid = 1'b0; m3_src = 0; m3_err = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      stall_m = 1'($urandom); bub_m = 1'($urandom);
      stall3  = 1'($urandom); bub3  = 1'($urandom);
      tick();
      checks += 5;
      if (o_data_m !== 64'h0) begin errors++; $display("[TB] FAIL reset_data got %h exp %h", o_data_m, 64'h0); end
      if (o_valid_m !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", o_valid_m); end
      if (o_src_m !== 2'd0)   begin errors++; $display("[TB] FAIL reset_src got %0d exp 0", o_src_m); end
      if (o_err_m !== 1'b0)   begin errors++; $display("[TB] FAIL reset_err got %b exp 0", o_err_m); end
      if (o_cnt_m !== 8'd0)   begin errors++; $display("[TB] FAIL reset_cnt got %0d exp 0", o_cnt_m); end
      checks += 2;
      if (o_data3 !== BV3)    begin errors++; $display("[TB] FAIL reset_data3 got %h exp %h", o_data3, BV3); end
      if (o_cnt3 !== 3'd0)    begin errors++; $display("[TB] FAIL reset_cnt3 got %0d exp 0", o_cnt3); end
    end
    sel_m = 2'd0; stall_m = 1'b0; bub_m = 1'b0;
    sel3  = 2'd0; stall3  = 1'b0; bub3  = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_load_sweep();
    logic [63:0] exp;
    for (int k = 0; k < 4; k++) in_main[k*64 +: 64] = 64'h1111_0000_0000_0000 * (k + 1);
    for (int k = 0; k < 4; k++) begin
      sel_m = 2'(k);
      tick();
      exp = 64'h1111_0000_0000_0000 * (k + 1);
      checks += 3;
      if (o_data_m !== exp)     begin errors++; $display("[TB] FAIL load_data sel=%0d got %h exp %h", k, o_data_m, exp); end
      if (o_valid_m !== 1'b1)   begin errors++; $display("[TB] FAIL load_valid sel=%0d got %b exp 1", k, o_valid_m); end
      if (o_src_m !== 2'(k))    begin errors++; $display("[TB] FAIL load_src got %0d exp %0d", o_src_m, k); end
    end
  endtask

  task automatic test_stall();
    logic [63:0] ch1;
    sel_m = 2'd2;
    tick();
    stall_m = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      for (int j = 0; j < 8; j++) in_main[j*32 +: 32] = $urandom;
      sel_m = 2'($urandom_range(0, 3));
      tick();
      checks += 3;
      if (o_data_m !== 64'h3333_0000_0000_0000) begin errors++; $display("[TB] FAIL stall_data got %h exp %h", o_data_m, 64'h3333_0000_0000_0000); end
      if (o_src_m !== 2'd2)  begin errors++; $display("[TB] FAIL stall_src got %0d exp 2", o_src_m); end
      if (o_cnt_m !== 8'(i)) begin errors++; $display("[TB] FAIL stall_cnt got %0d exp %0d", o_cnt_m, i); end
    end
    stall_m = 1'b0;
    sel_m = 2'd1;
    for (int j = 0; j < 8; j++) in_main[j*32 +: 32] = $urandom;
    ch1 = in_main[127:64];
    tick();
    checks += 3;
    if (o_cnt_m !== 8'd0)  begin errors++; $display("[TB] FAIL stall_release_cnt got %0d exp 0", o_cnt_m); end
    if (o_data_m !== ch1)  begin errors++; $display("[TB] FAIL stall_release_data got %h exp %h", o_data_m, ch1); end
    if (o_src_m !== 2'd1)  begin errors++; $display("[TB] FAIL stall_release_src got %0d exp 1", o_src_m); end
  endtask

  task automatic test_bubble_priority();
    sel_m = 2'd3;
    tick();
    stall_m = 1'b1;
    tick();
    tick();
    bub_m = 1'b1;
    tick();
    checks += 4;
    if (o_valid_m !== 1'b0)  begin errors++; $display("[TB] FAIL bubble_valid got %b exp 0", o_valid_m); end
    if (o_data_m !== 64'h0)  begin errors++; $display("[TB] FAIL bubble_data got %h exp 0", o_data_m); end
    if (o_cnt_m !== 8'd0)    begin errors++; $display("[TB] FAIL bubble_cnt got %0d exp 0", o_cnt_m); end
    if (o_src_m !== 2'd0)    begin errors++; $display("[TB] FAIL bubble_src got %0d exp 0", o_src_m); end
    stall_m = 1'b0; bub_m = 1'b0;
  endtask

  task automatic test_invalid_sel();
    logic [15:0] ch1;
    stall3 = 1'b1; sel3 = 2'd3;
    tick();
    checks += 1;
    if (o_err3 !== 1'b0) begin errors++; $display("[TB] FAIL inv_stall_noerr got %b exp 0", o_err3); end
    stall3 = 1'b0;
    tick();
    checks += 4;
    if (o_valid3 !== 1'b0) begin errors++; $display("[TB] FAIL inv_valid got %b exp 0", o_valid3); end
    if (o_err3 !== 1'b1)   begin errors++; $display("[TB] FAIL inv_err got %b exp 1", o_err3); end
    if (o_data3 !== BV3)   begin errors++; $display("[TB] FAIL inv_data got %h exp %h", o_data3, BV3); end
    if (o_src3 !== 2'd0)   begin errors++; $display("[TB] FAIL inv_src got %0d exp 0", o_src3); end
    sel3 = 2'd1;
    in3 = 48'h0123_4567_89AB;
    ch1 = in3[31:16];
    tick();
    checks += 4;
    if (o_valid3 !== 1'b1) begin errors++; $display("[TB] FAIL inv_reload_valid got %b exp 1", o_valid3); end
    if (o_err3 !== 1'b1)   begin errors++; $display("[TB] FAIL inv_sticky got %b exp 1", o_err3); end
    if (o_data3 !== ch1)   begin errors++; $display("[TB] FAIL inv_reload_data got %h exp %h", o_data3, ch1); end
    if (o_src3 !== 2'd1)   begin errors++; $display("[TB] FAIL inv_reload_src got %0d exp 1", o_src3); end
  endtask

  task automatic test_saturation();
    int exp;
    stall3 = 1'b0;
    tick();
    stall3 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      sel3 = 2'($urandom_range(0, 3));
      tick();
      exp = (i < 7) ? i : 7;
      checks += 1;
      if (o_cnt3 !== 3'(exp)) begin errors++; $display("[TB] FAIL sat_cnt edge %0d got %0d exp %0d", i, o_cnt3, exp); end
    end
    stall3 = 1'b0;
    sel3 = 2'd0;
    tick();
    checks += 1;
    if (o_cnt3 !== 3'd0) begin errors++; $display("[TB] FAIL sat_release got %0d exp 0", o_cnt3); end
  endtask

  task automatic test_async_reset();
    sel_m = 2'd1; stall_m = 1'b1; sel3 = 2'd3; stall3 = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    reset_models();
    #1;
    checks += 5;
    if (o_valid_m !== 1'b0) begin errors++; $display("[TB] FAIL async_valid got %b exp 0", o_valid_m); end
    if (o_data_m !== 64'h0) begin errors++; $display("[TB] FAIL async_data got %h exp 0", o_data_m); end
    if (o_cnt_m !== 8'd0)   begin errors++; $display("[TB] FAIL async_cnt got %0d exp 0", o_cnt_m); end
    if (o_err3 !== 1'b0)    begin errors++; $display("[TB] FAIL async_err3 got %b exp 0", o_err3); end
    if (o_data3 !== BV3)    begin errors++; $display("[TB] FAIL async_data3 got %h exp %h", o_data3, BV3); end
    stall_m = 1'b0; sel_m = 2'd3; sel3 = 2'd2;
    #1 rst = 1'b0;
    tick();
    checks += 3;
    if (o_valid_m !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_valid got %b exp 1", o_valid_m); end
    if (o_data_m !== in_main[255:192]) begin errors++; $display("[TB] FAIL post_reset_data got %h exp %h", o_data_m, in_main[255:192]); end
    if (o_src3 !== 2'd2)    begin errors++; $display("[TB] FAIL post_reset_src3 got %0d exp 2", o_src3); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      stall_m = ($urandom_range(0, 9) < 3); bub_m = ($urandom_range(0, 9) < 1);
      stall3  = ($urandom_range(0, 9) < 4); bub3  = ($urandom_range(0, 9) < 1);
      tick();
      checks += 10;
      if (o_data_m !== m_data)      begin errors++; $display("[TB] FAIL rnd_data #%0d got %h exp %h", n, o_data_m, m_data); end
      if (o_valid_m !== m_valid)    begin errors++; $display("[TB] FAIL rnd_valid #%0d got %b exp %b", n, o_valid_m, m_valid); end
      if (o_src_m !== 2'(m_src))    begin errors++; $display("[TB] FAIL rnd_src #%0d got %0d exp %0d", n, o_src_m, m_src); end
      if (o_err_m !== m_err)        begin errors++; $display("[TB] FAIL rnd_err #%0d got %b exp %b", n, o_err_m, m_err); end
      if (o_cnt_m !== 8'(m_cnt))    begin errors++; $display("[TB] FAIL rnd_cnt #%0d got %0d exp %0d", n, o_cnt_m, m_cnt); end
      if (o_data3 !== m3_data)      begin errors++; $display("[TB] FAIL rnd_data3 #%0d got %h exp %h", n, o_data3, m3_data); end
      if (o_valid3 !== m3_valid)    begin errors++; $display("[TB] FAIL rnd_valid3 #%0d got %b exp %b", n, o_valid3, m3_valid); end
      if (o_src3 !== 2'(m3_src))    begin errors++; $display("[TB] FAIL rnd_src3 #%0d got %0d exp %0d", n, o_src3, m3_src); end
      if (o_err3 !== m3_err)        begin errors++; $display("[TB] FAIL rnd_err3 #%0d got %b exp %b", n, o_err3, m3_err); end
      if (o_cnt3 !== 3'(m3_cnt))    begin errors++; $display("[TB] FAIL rnd_cnt3 #%0d got %0d exp %0d", n, o_cnt3, m3_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_main = '0; in3 = '0;
    sel_m = 2'd0; stall_m = 1'b0; bub_m = 1'b0;
    sel3 = 2'd0; stall3 = 1'b0; bub3 = 1'b0;
    reset_models();
    #2;
    test_reset();
    test_load_sweep();
    test_stall();
    test_bubble_priority();
    test_invalid_sel();
    test_saturation();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
